// File: rtl/move_entry_fsm.sv
// -----------------------------------------------------------------------------
// move_entry_fsm
// Player-side move source for a 9x9 Go board controller. Debounced push-button
// levels become cursor steps, place commands and pass commands. A place on an
// occupied point is rejected. The block tracks whose turn it is and ignores
// all button activity for COOLDOWN_CYCLES cycles after each issued move.
//
// Optional feature macro: AUTOREPEAT_EN
//   When defined, a held direction button auto-repeats after REPEAT_DELAY
//   cycles and then every REPEAT_PERIOD cycles. When undefined, only edges
//   step the cursor and no repeat counter exists.
//
// Ports
//   clk_in      in   system clock
//   reset       in   asynchronous active-high reset
//   btn_*       in   debounced button levels (asynchronous to clk_in)
//   board       in   live board, board[row][col] is a 2-bit point:
//                    2'b00 empty, 2'b01 black, 2'b10 white
//   move        out  {row,col} of the issued move, 8'hFF = pass
//   move_avail  out  one-cycle pulse qualifying move
//   cursor_row  out  0..8, row 0 = top
//   cursor_col  out  0..8, col 0 = left
//   turn        out  2'b01 black to move, 2'b10 white to move
//   reject      out  one-cycle pulse when placing on an occupied point
// -----------------------------------------------------------------------------
module move_entry_fsm #(
   parameter int COOLDOWN_CYCLES = 16,
   parameter int REPEAT_DELAY    = 2**20,
   parameter int REPEAT_PERIOD   = 2**18
) (
   input  logic                 clk_in,
   input  logic                 reset,
   input  logic                 btn_up,
   input  logic                 btn_down,
   input  logic                 btn_left,
   input  logic                 btn_right,
   input  logic                 btn_place,
   input  logic                 btn_pass,
   input  logic [8:0][8:0][1:0] board,
   output logic [7:0]           move,
   output logic                 move_avail,
   output logic [3:0]           cursor_row,
   output logic [3:0]           cursor_col,
   output logic [1:0]           turn,
   output logic                 reject
);

   // A zero-length cooldown or repeat interval would make the counters
   // meaningless, so refuse to elaborate with such values.
   if (COOLDOWN_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_param_check
      $error("move_entry_fsm: cycle parameters must be >= 1");
   end

   // Bit positions inside the packed button vector.
   localparam int B_PLACE = 1;
   localparam int B_PASS  = 0;

   localparam logic [1:0] D_UP    = 2'd0;
   localparam logic [1:0] D_DOWN  = 2'd1;
   localparam logic [1:0] D_LEFT  = 2'd2;
   localparam logic [1:0] D_RIGHT = 2'd3;

   localparam int              CD_W    = $clog2(COOLDOWN_CYCLES + 1);
   localparam logic [CD_W-1:0] CD_LAST = CD_W'(COOLDOWN_CYCLES - 1);

   typedef enum logic {IDLE, COOLDOWN} state_t;

   // Priority encoder over {up,down,left,right}: up > down > left > right.
   function automatic logic [1:0] prio_dir(input logic [3:0] v);
      logic [1:0] d;
      if (v[3])      d = D_UP;
      else if (v[2]) d = D_DOWN;
      else if (v[1]) d = D_LEFT;
      else           d = D_RIGHT;
      return d;
   endfunction

   logic [5:0] btn_raw;
   logic [5:0] sync1_q, sync2_q, prev_q;
   logic [5:0] edge_w;

   state_t          state_q, state_d;
   logic [CD_W-1:0] cd_cnt_q, cd_cnt_d;
   logic [7:0]      move_q, move_d;
   logic            avail_q, avail_d;
   logic            reject_q, reject_d;
   logic [3:0]      row_q, row_d;
   logic [3:0]      col_q, col_d;
   logic [1:0]      turn_q, turn_d;

   logic            accept;
   logic            step_en;
   logic [1:0]      step_dir;
   logic [1:0]      point;

   assign btn_raw = {btn_up, btn_down, btn_left, btn_right, btn_place, btn_pass};
   assign edge_w  = sync2_q & ~prev_q;

`ifdef AUTOREPEAT_EN
   localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int RPT_W   = $clog2(RPT_MAX + 1);

   logic             rpt_act_q, rpt_act_d;
   logic             rpt_wait_q, rpt_wait_d;   // 1: still in the initial delay
   logic [1:0]       rpt_dir_q, rpt_dir_d;
   logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
   logic             lvl_en;
   logic [1:0]       lvl_dir;

   // The level that keeps a repeat alive is the synchronized one, with the
   // same priority as edges so pressing a higher direction cancels it.
   assign lvl_en  = |sync2_q[5:2];
   assign lvl_dir = prio_dir(sync2_q[5:2]);

   always_ff @(posedge clk_in or posedge reset) begin
      if (reset) begin
         rpt_act_q  <= 1'b0;
         rpt_wait_q <= 1'b1;
         rpt_dir_q  <= D_UP;
         rpt_cnt_q  <= '0;
      end else begin
         rpt_act_q  <= rpt_act_d;
         rpt_wait_q <= rpt_wait_d;
         rpt_dir_q  <= rpt_dir_d;
         rpt_cnt_q  <= rpt_cnt_d;
      end
   end
`endif

   always_ff @(posedge clk_in or posedge reset) begin
      if (reset) begin
         sync1_q  <= '0;
         sync2_q  <= '0;
         prev_q   <= '0;
         state_q  <= IDLE;
         cd_cnt_q <= '0;
         move_q   <= 8'h00;
         avail_q  <= 1'b0;
         reject_q <= 1'b0;
         row_q    <= 4'd4;
         col_q    <= 4'd4;
         turn_q   <= 2'b01;
      end else begin
         sync1_q  <= btn_raw;
         sync2_q  <= sync1_q;
         prev_q   <= sync2_q;
         state_q  <= state_d;
         cd_cnt_q <= cd_cnt_d;
         move_q   <= move_d;
         avail_q  <= avail_d;
         reject_q <= reject_d;
         row_q    <= row_d;
         col_q    <= col_d;
         turn_q   <= turn_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cd_cnt_d = cd_cnt_q;
      move_d   = move_q;
      avail_d  = 1'b0;
      reject_d = 1'b0;
      row_d    = row_q;
      col_d    = col_q;
      turn_d   = turn_q;
      accept   = 1'b0;
      step_en  = 1'b0;
      step_dir = D_UP;
      point    = board[row_q][col_q];
`ifdef AUTOREPEAT_EN
      // Repeat state clears unless the IDLE branch below keeps it alive.
      rpt_act_d  = 1'b0;
      rpt_wait_d = 1'b1;
      rpt_dir_d  = rpt_dir_q;
      rpt_cnt_d  = '0;
`endif

      case (state_q)
         IDLE: begin
            // Place wins over pass, even when the place is rejected.
            if (edge_w[B_PLACE]) begin
               if (point == 2'b00) begin
                  accept = 1'b1;
                  move_d = {row_q, col_q};
               end else begin
                  reject_d = 1'b1;
               end
            end else if (edge_w[B_PASS]) begin
               accept = 1'b1;
               move_d = 8'hFF;
            end

            if (accept) begin
               avail_d  = 1'b1;
               turn_d   = (turn_q == 2'b01) ? 2'b10 : 2'b01;
               state_d  = COOLDOWN;
               cd_cnt_d = '0;
            end else if (|edge_w[5:2]) begin
               step_en  = 1'b1;
               step_dir = prio_dir(edge_w[5:2]);
`ifdef AUTOREPEAT_EN
               rpt_act_d  = 1'b1;
               rpt_dir_d  = step_dir;
               rpt_cnt_d  = RPT_W'(1);
               rpt_wait_d = 1'b1;
`endif
            end
`ifdef AUTOREPEAT_EN
            else if (rpt_act_q && lvl_en && (lvl_dir == rpt_dir_q)) begin
               rpt_act_d = 1'b1;
               if ((rpt_wait_q && (rpt_cnt_q == RPT_W'(REPEAT_DELAY))) ||
                   (!rpt_wait_q && (rpt_cnt_q == RPT_W'(REPEAT_PERIOD)))) begin
                  step_en    = 1'b1;
                  step_dir   = rpt_dir_q;
                  rpt_cnt_d  = RPT_W'(1);
                  rpt_wait_d = 1'b0;
               end else begin
                  rpt_cnt_d  = rpt_cnt_q + 1'b1;
                  rpt_wait_d = rpt_wait_q;
               end
            end
`endif
         end

         COOLDOWN: begin
            // Edges are simply not looked at here, so they are dropped.
            if (cd_cnt_q == CD_LAST) begin
               state_d  = IDLE;
               cd_cnt_d = '0;
            end else begin
               cd_cnt_d = cd_cnt_q + 1'b1;
            end
         end

         default: state_d = IDLE;
      endcase

      if (step_en) begin
         case (step_dir)
            D_UP:    row_d = (row_q == 4'd0) ? 4'd8 : row_q - 4'd1;
            D_DOWN:  row_d = (row_q == 4'd8) ? 4'd0 : row_q + 4'd1;
            D_LEFT:  col_d = (col_q == 4'd0) ? 4'd8 : col_q - 4'd1;
            default: col_d = (col_q == 4'd8) ? 4'd0 : col_q + 4'd1;
         endcase
      end
   end

   assign move       = move_q;
   assign move_avail = avail_q;
   assign reject     = reject_q;
   assign cursor_row = row_q;
   assign cursor_col = col_q;
   assign turn       = turn_q;

endmodule
